// File: rtl/fifo_unpacker_pkg.sv
// Shared types and helpers for the FIFO read-side word unpacker.
package fifo_unpacker_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_Q, DRAIN} unpack_state_t;

    // Number of narrow beats carried by one FIFO word.
    function automatic int unsigned ratio(input int unsigned inW, input int unsigned outW);
        return inW / outW;
    endfunction

    // Slice position inside the held word for beat number cnt.
    function automatic int unsigned slice_sel(input int unsigned cnt, input int unsigned ratioVal,
                                              input bit lsbFirst);
        return lsbFirst ? cnt : (ratioVal - 1 - cnt);
    endfunction

endpackage

// File: rtl/fifo_unpacker_if.sv
// FIFO read port plus narrow valid/ready output stream of the unpacker.
interface fifo_unpacker_if #(
    parameter int unsigned IN_WIDTH  = 128,
    parameter int unsigned OUT_WIDTH = 32
);
    logic                 fifo_mty;
    logic [IN_WIDTH-1:0]  fifo_q;
    logic                 fifo_rd;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    // Unpacker side: pops the FIFO and sources the beat stream.
    modport master (
        input  fifo_mty, fifo_q, out_ready,
        output fifo_rd, out_data, out_valid, out_last
    );

    // Environment side: FIFO read port and downstream sink.
    modport slave (
        output fifo_mty, fifo_q, out_ready,
        input  fifo_rd, out_data, out_valid, out_last
    );
endinterface

// File: rtl/fifo_unpacker.sv
// Pops wide words from the synchronous FIFO and serialises each into
// IN_WIDTH/OUT_WIDTH narrow beats, flagging the last slice and counting
// fully drained words.
module fifo_unpacker
    import fifo_unpacker_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 128,
    parameter int unsigned OUT_WIDTH = 32,
    parameter bit          LSB_FIRST = 1'b1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 flush,
    fifo_unpacker_if.master      bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int unsigned RATIO = ratio(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    generate
        if (RATIO < 2 || (IN_WIDTH % OUT_WIDTH) != 0) begin : gBadRatio
            $error("fifo_unpacker: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
        end
    endgenerate

    unpack_state_t        state;
    unpack_state_t        stateNext;
    logic [IN_WIDTH-1:0]  shiftReg;
    logic [SEL_W-1:0]     cnt;
    logic [SEL_W-1:0]     sliceIdx;
    logic [CNT_WIDTH-1:0] wordCnt;
    logic                 handshake;
    logic                 lastSlice;
    logic                 popReq;

    assign lastSlice = (cnt == SEL_W'(RATIO - 1));
    assign handshake = (state == DRAIN) && bus.out_ready;
    assign sliceIdx  = SEL_W'(slice_sel(32'(cnt), RATIO, LSB_FIRST));

    // Next-state and pop request; flush overrides everything, including a last-beat pop.
    always_comb begin
        stateNext = state;
        popReq    = 1'b0;
        unique case (state)
            IDLE: begin
                popReq = !bus.fifo_mty && !flush;
                if (popReq) stateNext = WAIT_Q;
            end
            WAIT_Q: stateNext = DRAIN;
            DRAIN: begin
                if (handshake && lastSlice) begin
                    if (!bus.fifo_mty) begin
                        popReq    = 1'b1;
                        stateNext = WAIT_Q;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
        if (flush) begin
            popReq    = 1'b0;
            stateNext = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state <= IDLE;
        else       state <= stateNext;
    end

    // Word capture, slice counter and drained-word counter.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            shiftReg <= '0;
            cnt      <= '0;
            wordCnt  <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            unique case (state)
                WAIT_Q: begin
                    shiftReg <= bus.fifo_q;
                    cnt      <= '0;
                end
                DRAIN: begin
                    if (handshake) begin
                        if (lastSlice) begin
                            cnt     <= '0;
                            wordCnt <= wordCnt + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pop is also gated by reset so the FIFO never sees a request while held in reset.
    assign bus.fifo_rd   = popReq && arst;
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_last  = bus.out_valid && lastSlice;
    assign bus.out_data  = bus.out_valid ? shiftReg[sliceIdx*OUT_WIDTH +: OUT_WIDTH] : '0;
    assign busy          = (state != IDLE);
    assign word_cnt      = wordCnt;

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed, table-driven bench for fifo_unpacker (LSB-first and MSB-first instances).
module tb_fifo_unpacker;

    typedef struct {
        int          push;
        bit          rdy;
        bit          fl;
        bit          rd;
        bit          v;
        bit          l;
        logic [31:0] d;
        bit          b;
        logic [15:0] c;
    } vec_t;

    logic        clk;
    logic        arst;
    logic        flushA;
    logic        flushB;
    logic        busyA;
    logic        busyB;
    logic [15:0] cntA;
    logic [15:0] cntB;

    int total = 0;
    int bad   = 0;

    logic [127:0] words [0:9];
    logic [127:0] qA [$];
    logic [127:0] qB [$];
    int nextA = 0;
    int nextB = 0;

    vec_t tabA [$];
    vec_t tabB [$];
    vec_t tabW [$];

    fifo_unpacker_if #(.IN_WIDTH(128), .OUT_WIDTH(32)) ifA ();
    fifo_unpacker_if #(.IN_WIDTH(128), .OUT_WIDTH(32)) ifB ();

    fifo_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(32), .LSB_FIRST(1'b1), .CNT_WIDTH(16)) uA (
        .clk(clk), .arst(arst), .flush(flushA), .bus(ifA), .busy(busyA), .word_cnt(cntA)
    );

    fifo_unpacker #(.IN_WIDTH(128), .OUT_WIDTH(32), .LSB_FIRST(1'b0), .CNT_WIDTH(16)) uB (
        .clk(clk), .arst(arst), .flush(flushB), .bus(ifB), .busy(busyB), .word_cnt(cntB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (got running, expected done)");
        $fatal(1);
    end

    function automatic vec_t mk(int push, int rdy, int fl, int rd, int v, int l,
                                logic [31:0] d, int b, int c);
        vec_t t;
        t.push = push;
        t.rdy  = (rdy != 0);
        t.fl   = (fl != 0);
        t.rd   = (rd != 0);
        t.v    = (v != 0);
        t.l    = (l != 0);
        t.d    = d;
        t.b    = (b != 0);
        t.c    = 16'(c);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of FIFO model: pop on the edge that samples rd with !mty.
    task automatic step();
        logic popA;
        logic popB;
        popA = ifA.fifo_rd && !ifA.fifo_mty;
        popB = ifB.fifo_rd && !ifB.fifo_mty;
        @(posedge clk);
        #1;
        if (popA && qA.size() > 0) ifA.fifo_q = qA.pop_front();
        if (popB && qB.size() > 0) ifB.fifo_q = qB.pop_front();
        ifA.fifo_mty = (qA.size() == 0);
        ifB.fifo_mty = (qB.size() == 0);
        @(negedge clk);
    endtask

    task automatic runRow(input vec_t r, input bit useB, input string tag);
        logic        aRd;
        logic        aV;
        logic        aL;
        logic [31:0] aD;
        logic        aB;
        logic [15:0] aC;
        for (int k = 0; k < r.push; k++) begin
            if (useB) begin
                qB.push_back(words[nextB]);
                nextB++;
                ifB.fifo_mty = 1'b0;
            end else begin
                qA.push_back(words[nextA]);
                nextA++;
                ifA.fifo_mty = 1'b0;
            end
        end
        if (useB) begin
            ifB.out_ready = r.rdy;
            flushB        = r.fl;
        end else begin
            ifA.out_ready = r.rdy;
            flushA        = r.fl;
        end
        #1;
        if (useB) begin
            aRd = ifB.fifo_rd; aV = ifB.out_valid; aL = ifB.out_last;
            aD  = ifB.out_data; aB = busyB; aC = cntB;
        end else begin
            aRd = ifA.fifo_rd; aV = ifA.out_valid; aL = ifA.out_last;
            aD  = ifA.out_data; aB = busyA; aC = cntA;
        end
        chk({tag, ".fifo_rd"},   32'(aRd), 32'(r.rd));
        chk({tag, ".out_valid"}, 32'(aV),  32'(r.v));
        chk({tag, ".out_last"},  32'(aL),  32'(r.l));
        chk({tag, ".out_data"},  aD,       r.d);
        chk({tag, ".busy"},      32'(aB),  32'(r.b));
        chk({tag, ".word_cnt"},  32'(aC),  32'(r.c));
        step();
    endtask

    initial begin
        words[0] = 128'h33333333_22222222_11111111_00000000;
        for (int k = 1; k < 10; k++) begin
            for (int s = 0; s < 4; s++) begin
                words[k][s*32 +: 32] = 32'hA000 + 32'(k * 256 + s);
            end
        end

        // MSB-first instance: one word.
        tabB.push_back(mk(1,1,0, 1,0,0,32'h0,       0,0));
        tabB.push_back(mk(0,1,0, 0,0,0,32'h0,       1,0));
        tabB.push_back(mk(0,1,0, 0,1,0,32'h33333333,1,0));
        tabB.push_back(mk(0,1,0, 0,1,0,32'h22222222,1,0));
        tabB.push_back(mk(0,1,0, 0,1,0,32'h11111111,1,0));
        tabB.push_back(mk(0,1,0, 0,1,1,32'h00000000,1,0));
        tabB.push_back(mk(0,1,0, 0,0,0,32'h0,       0,1));

        // LSB-first: single word.
        tabA.push_back(mk(1,1,0, 1,0,0,32'h0,       0,0));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,       1,0));
        tabA.push_back(mk(0,1,0, 0,1,0,32'h00000000,1,0));
        tabA.push_back(mk(0,1,0, 0,1,0,32'h11111111,1,0));
        tabA.push_back(mk(0,1,0, 0,1,0,32'h22222222,1,0));
        tabA.push_back(mk(0,1,0, 0,1,1,32'h33333333,1,0));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,       0,1));
        // Three words back to back.
        tabA.push_back(mk(3,1,0, 1,0,0,32'h0,   0,1));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   1,1));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA100,1,1));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA101,1,1));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA102,1,1));
        tabA.push_back(mk(0,1,0, 1,1,1,32'hA103,1,1));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   1,2));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA200,1,2));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA201,1,2));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA202,1,2));
        tabA.push_back(mk(0,1,0, 1,1,1,32'hA203,1,2));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   1,3));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA300,1,3));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA301,1,3));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA302,1,3));
        tabA.push_back(mk(0,1,0, 0,1,1,32'hA303,1,3));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   0,4));
        // Ready toggling 1,0,0,1 with a further word arriving mid-stall.
        tabA.push_back(mk(1,1,0, 1,0,0,32'h0,   0,4));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   1,4));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA400,1,4));
        tabA.push_back(mk(0,0,0, 0,1,0,32'hA401,1,4));
        tabA.push_back(mk(0,0,0, 0,1,0,32'hA401,1,4));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA401,1,4));
        tabA.push_back(mk(1,0,0, 0,1,0,32'hA402,1,4));
        tabA.push_back(mk(0,0,0, 0,1,0,32'hA402,1,4));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA402,1,4));
        tabA.push_back(mk(0,0,0, 0,1,1,32'hA403,1,4));
        tabA.push_back(mk(0,0,0, 0,1,1,32'hA403,1,4));
        tabA.push_back(mk(0,1,0, 1,1,1,32'hA403,1,4));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   1,5));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA500,1,5));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA501,1,5));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA502,1,5));
        tabA.push_back(mk(0,1,0, 0,1,1,32'hA503,1,5));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   0,6));
        // Flush on beat 2 with the FIFO still holding the next word.
        tabA.push_back(mk(2,1,0, 1,0,0,32'h0,   0,6));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   1,6));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA600,1,6));
        tabA.push_back(mk(0,1,1, 0,1,0,32'hA601,1,6));
        tabA.push_back(mk(0,1,0, 1,0,0,32'h0,   0,6));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   1,6));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA700,1,6));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA701,1,6));
        tabA.push_back(mk(0,1,0, 0,1,0,32'hA702,1,6));
        tabA.push_back(mk(0,1,0, 0,1,1,32'hA703,1,6));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   0,7));
        // Flush in IDLE suppresses the pop; then start a word for the reset test.
        tabA.push_back(mk(1,1,1, 0,0,0,32'h0,   0,7));
        tabA.push_back(mk(0,1,0, 1,0,0,32'h0,   0,7));
        tabA.push_back(mk(0,1,0, 0,0,0,32'h0,   1,7));

        // Counter wrap from a preloaded 0xFFFF.
        tabW.push_back(mk(1,1,0, 1,0,0,32'h0,   0,16'hFFFF));
        tabW.push_back(mk(0,1,0, 0,0,0,32'h0,   1,16'hFFFF));
        tabW.push_back(mk(0,1,0, 0,1,0,32'hA900,1,16'hFFFF));
        tabW.push_back(mk(0,1,0, 0,1,0,32'hA901,1,16'hFFFF));
        tabW.push_back(mk(0,1,0, 0,1,0,32'hA902,1,16'hFFFF));
        tabW.push_back(mk(0,1,0, 0,1,1,32'hA903,1,16'hFFFF));
        tabW.push_back(mk(0,1,0, 0,0,0,32'h0,   0,16'h0000));

        arst          = 1'b0;
        flushA        = 1'b0;
        flushB        = 1'b0;
        ifA.out_ready = 1'b0;
        ifB.out_ready = 1'b0;
        ifA.fifo_q    = '0;
        ifB.fifo_q    = '0;
        ifA.fifo_mty  = 1'b0;
        ifB.fifo_mty  = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("rst.fifo_rd",   32'(ifA.fifo_rd),   32'h0);
        chk("rst.out_valid", 32'(ifA.out_valid), 32'h0);
        chk("rst.out_last",  32'(ifA.out_last),  32'h0);
        chk("rst.out_data",  ifA.out_data,       32'h0);
        chk("rst.busy",      32'(busyA),         32'h0);
        chk("rst.word_cnt",  32'(cntA),          32'h0);
        ifA.fifo_mty = 1'b1;
        arst         = 1'b1;
        @(negedge clk);

        for (int i = 0; i < tabB.size(); i++) runRow(tabB[i], 1'b1, $sformatf("msb%0d", i));
        for (int i = 0; i < tabA.size(); i++) runRow(tabA[i], 1'b0, $sformatf("lsb%0d", i));

        // Asynchronous reset in the middle of a word.
        ifA.out_ready = 1'b0;
        #1;
        chk("mid.out_valid", 32'(ifA.out_valid), 32'h1);
        chk("mid.out_data",  ifA.out_data,       32'hA800);
        #2;
        arst = 1'b0;
        #1;
        chk("arst.fifo_rd",   32'(ifA.fifo_rd),   32'h0);
        chk("arst.out_valid", 32'(ifA.out_valid), 32'h0);
        chk("arst.out_last",  32'(ifA.out_last),  32'h0);
        chk("arst.out_data",  ifA.out_data,       32'h0);
        chk("arst.busy",      32'(busyA),         32'h0);
        chk("arst.word_cnt",  32'(cntA),          32'h0);
        @(negedge clk);
        arst = 1'b1;
        #1;
        chk("rel.out_valid", 32'(ifA.out_valid), 32'h0);
        chk("rel.busy",      32'(busyA),         32'h0);
        @(negedge clk);

        force uA.wordCnt = 16'hFFFF;
        #1;
        release uA.wordCnt;
        chk("wrap.preload", 32'(cntA), 32'h0000FFFF);
        @(negedge clk);
        for (int i = 0; i < tabW.size(); i++) runRow(tabW[i], 1'b0, $sformatf("wrap%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_unpacker.md
Name: fifo_unpacker

Overview:
- Read-side consumer of the team's synchronous FIFO.
- Pops one wide word per transaction via the FIFO's rd/q/mty handshake, then serialises it into IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready stream.
- Sits between the FIFO's read interface and the downstream narrow datapath.
- Marks the final slice of each word and keeps a wrapping count of words drained.

Parameters:
- IN_WIDTH, 128, FIFO word width; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 32, output beat width.
- LSB_FIRST, 1, 1 = slice [OUT_WIDTH-1:0] goes out first; 0 = MSB slice first.
- CNT_WIDTH, 16, width of the word counter.

Ports:
- clk  in  1  block clock, all logic on rising edge.
- arst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current word.
- fifo_mty  in  1  FIFO empty flag.
- fifo_q  in  IN_WIDTH  FIFO registered read data.
- fifo_rd  out  1  FIFO pop request.
- out_data  out  OUT_WIDTH  current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_last  out  1  beat is the final slice of its word.
- busy  out  1  state != IDLE.
- word_cnt  out  CNT_WIDTH  words fully drained since reset.

Behaviour:
- Reset: clk is the single clock; arst is asynchronous, active-low.
  - While arst = 0: state = IDLE, shift register = 0, slice counter = 0, word_cnt = 0.
  - Outputs during reset: fifo_rd = 0, out_valid = 0, out_last = 0, out_data = 0, busy = 0.
- Constants: RATIO = IN_WIDTH/OUT_WIDTH, RATIO >= 2 (elaboration error otherwise). Slice counter width = $clog2(RATIO).
- FIFO contract: fifo_q updates on the same edge that samples fifo_rd = 1 with fifo_mty = 0, so data is valid the cycle after rd. fifo_rd is never asserted while fifo_mty = 1.
- States: IDLE, WAIT_Q, DRAIN.
- IDLE:
  - fifo_rd = !fifo_mty & !flush (combinational).
  - If fifo_rd = 1 -> WAIT_Q; else stay in IDLE.
- WAIT_Q:
  - Capture fifo_q into the shift register; slice counter = 0 -> DRAIN.
  - out_valid = 0 in this cycle.
- DRAIN:
  - out_valid = 1.
  - out_data = slice[cnt] with LSB_FIRST ordering.
  - out_last = (cnt == RATIO-1).
- Hold rule: while out_valid = 1 and out_ready = 0, out_data, out_valid and out_last hold stable. out_valid never drops without a handshake except on flush or reset.
- Handshake (out_valid & out_ready), not last: cnt += 1.
- Handshake on last beat:
  - word_cnt += 1; wraps 2^CNT_WIDTH-1 -> 0.
  - If !fifo_mty, fifo_rd = 1 this cycle -> WAIT_Q (back-to-back pop).
  - Otherwise -> IDLE.
- Throughput: RATIO beats per RATIO+1 cycles under continuous ready and a non-empty FIFO. The single WAIT_Q bubble per word is accepted.
- flush = 1 (any state): next state = IDLE, cnt = 0, fifo_rd = 0 this cycle.
  - Flush overrides a same-cycle handshake: the beat is not counted and word_cnt is unchanged.
  - A word already popped, or in WAIT_Q, is discarded.
- fifo_mty is ignored in WAIT_Q and in DRAIN except on the last-beat handshake.
- Reset mid-word: the partially drained word is lost and the FIFO is not rewound.
- busy = (state != IDLE).

Decomposition:
- Package fifo_unpacker_pkg holds:
  - typedef enum logic [1:0] {IDLE, WAIT_Q, DRAIN} unpack_state_t.
  - function ratio(in_w, out_w) returning in_w/out_w.
  - function slice_sel returning the slice index for a given cnt and LSB_FIRST.
- Single module; no sub-module. Slice select is a mux indexed by cnt.

Test Plan:
- Push 0x33333333_22222222_11111111_00000000, hold out_ready = 1, LSB_FIRST = 1.
  -> fifo_rd pulses one cycle; beats 0x00000000, 0x11111111, 0x22222222, 0x33333333 on consecutive cycles; out_last only on the 4th; word_cnt = 1; state returns to IDLE.
- Same word with LSB_FIRST = 0.
  -> beat order 0x33333333, 0x22222222, 0x11111111, 0x00000000.
- Three words queued, out_ready = 1.
  -> 12 beats over 15 cycles; fifo_rd asserted on each last-beat handshake; exactly one out_valid = 0 cycle between words; word_cnt = 3.
- out_ready toggled 1,0,0,1,... mid-word.
  -> out_data and out_last stable while stalled; no slice skipped or repeated; fifo_rd = 0 throughout the stall.
- Assert flush on beat 2 of a word with the FIFO still non-empty.
  -> next cycle state = IDLE and out_valid = 0; word_cnt unchanged; next pop occurs the following cycle; next beats come from the next FIFO word, starting at slice 0.
- Drive arst = 0 asynchronously (between clock edges) during DRAIN; preload word_cnt = 0xFFFF before a further word.
  -> outputs go to reset values immediately on arst assertion, without waiting for a clock edge; after release, one drained word wraps word_cnt 0xFFFF -> 0x0000.
